// File: rtl/cfg_pkt_decoder.sv
// Configuration packet decoder: parses header/key/payload word streams and
// turns matching multicast config packets into register-bank write strobes.
module cfg_pkt_decoder #(
  parameter logic [31:0] CFG_KEY = 32'hffff_fe00,
  parameter logic [31:0] CFG_MSK = 32'hffff_ff00,
  parameter int unsigned TOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pkt_data_in,
  input  logic        pkt_vld_in,
  output logic        pkt_rdy_out,
  output logic [7:0]  prx_addr_out,
  output logic [31:0] prx_data_out,
  output logic        prx_vld_out,
  output logic        cfg_cnt_out,
  output logic        drp_cnt_out,
  output logic        err_cnt_out
);

  localparam int CW = (TOUT < 1) ? 1 : $clog2(TOUT + 1);
  localparam logic [CW-1:0] TOUT_C = CW'(TOUT);

  typedef enum logic [1:0] {
    HDR = 2'd0,
    KEY = 2'd1,
    PLD = 2'd2
  } state_t;

  function automatic logic is_cfg(input logic [1:0] typ, input logic [31:0] key);
    return (typ == 2'b00) && ((key & CFG_MSK) == (CFG_KEY & CFG_MSK));
  endfunction

  function automatic logic [CW-1:0] idle_inc(input logic [CW-1:0] c);
    return (c == TOUT_C) ? c : c + CW'(1);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          pld_q, pld_d;
  logic [1:0]    type_q, type_d;
  logic [31:0]   key_q, key_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          vld_q, vld_d;
  logic          cfg_q, cfg_d;
  logic          drp_q, drp_d;
  logic          err_q, err_d;
  logic          xfer;

  // Ready is a pure function of reset so a word can land on the very first
  // edge after reset is released.
  assign pkt_rdy_out = ~reset;
  assign xfer        = pkt_vld_in & pkt_rdy_out;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    pld_d   = pld_q;
    type_d  = type_q;
    key_d   = key_q;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    cfg_d   = 1'b0;
    drp_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      HDR: begin
        idle_d = '0;
        if (xfer) begin
          pld_d   = pkt_data_in[1];
          type_d  = pkt_data_in[7:6];
          state_d = KEY;
        end
      end
      KEY: begin
        if (xfer) begin
          key_d  = pkt_data_in;
          idle_d = '0;
          if (pld_q) begin
            state_d = PLD;
          end else begin
            // A config packet must carry a payload; without one it is an error.
            state_d = HDR;
            if (is_cfg(type_q, pkt_data_in)) err_d = 1'b1;
            else                             drp_d = 1'b1;
          end
        end else if (idle_q == TOUT_C) begin
          state_d = HDR;
          idle_d  = '0;
          err_d   = 1'b1;
        end else begin
          idle_d = idle_inc(idle_q);
        end
      end
      PLD: begin
        if (xfer) begin
          idle_d  = '0;
          state_d = HDR;
          if (is_cfg(type_q, key_q)) begin
            vld_d  = 1'b1;
            cfg_d  = 1'b1;
            addr_d = key_q[7:0];
            data_d = pkt_data_in;
          end else begin
            drp_d = 1'b1;
          end
        end else if (idle_q == TOUT_C) begin
          state_d = HDR;
          idle_d  = '0;
          err_d   = 1'b1;
        end else begin
          idle_d = idle_inc(idle_q);
        end
      end
      default: begin
        state_d = HDR;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HDR;
      idle_q  <= '0;
      addr_q  <= 8'd0;
      data_q  <= 32'd0;
      vld_q   <= 1'b0;
      cfg_q   <= 1'b0;
      drp_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      cfg_q   <= cfg_d;
      drp_q   <= drp_d;
      err_q   <= err_d;
    end
  end

  // Packet fields are only consumed after the FSM has latched them, so they
  // need no reset.
  always_ff @(posedge clk) begin
    pld_q  <= pld_d;
    type_q <= type_d;
    key_q  <= key_d;
  end

  assign prx_addr_out = addr_q;
  assign prx_data_out = data_q;
  assign prx_vld_out  = vld_q;
  assign cfg_cnt_out  = cfg_q;
  assign drp_cnt_out  = drp_q;
  assign err_cnt_out  = err_q;

endmodule

// File: tb/tb_cfg_pkt_decoder.sv
// Bench for cfg_pkt_decoder: directed scenarios then random traffic, all
// compared every cycle against a packet-level reference model.
module tb_cfg_pkt_decoder;

  localparam logic [31:0] KEYV = 32'hffff_fe00;
  localparam logic [31:0] MSKV = 32'hffff_ff00;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        vin;
  logic        rdy, pvld, cfgp, drpp, errp;
  logic [7:0]  paddr;
  logic [31:0] pdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: words collected so far in the current packet.
  logic [31:0] pkt[$];
  int          idle;
  logic        e_vld, e_cfg, e_drp, e_err;
  logic [7:0]  e_addr;
  logic [31:0] e_data;

  cfg_pkt_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .pkt_data_in (din),
    .pkt_vld_in  (vin),
    .pkt_rdy_out (rdy),
    .prx_addr_out(paddr),
    .prx_data_out(pdata),
    .prx_vld_out (pvld),
    .cfg_cnt_out (cfgp),
    .drp_cnt_out (drpp),
    .err_cnt_out (errp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pkt.delete();
    idle   = 0;
    e_vld  = 1'b0;
    e_cfg  = 1'b0;
    e_drp  = 1'b0;
    e_err  = 1'b0;
    e_addr = 8'd0;
    e_data = 32'd0;
  endtask

  function automatic logic match(input logic [31:0] hdr, input logic [31:0] key);
    return (hdr[7:6] == 2'b00) && ((key & MSKV) == (KEYV & MSKV));
  endfunction

  task automatic model_edge(input logic x, input logic [31:0] d);
    e_vld = 1'b0;
    e_cfg = 1'b0;
    e_drp = 1'b0;
    e_err = 1'b0;
    if (x) begin
      idle = 0;
      pkt.push_back(d);
      if (pkt.size() == 2 && !pkt[0][1]) begin
        if (match(pkt[0], pkt[1])) e_err = 1'b1;
        else                       e_drp = 1'b1;
        pkt.delete();
      end else if (pkt.size() == 3) begin
        if (match(pkt[0], pkt[1])) begin
          e_vld  = 1'b1;
          e_cfg  = 1'b1;
          e_addr = pkt[1][7:0];
          e_data = pkt[2];
        end else begin
          e_drp = 1'b1;
        end
        pkt.delete();
      end
    end else if (pkt.size() != 0) begin
      if (idle == TO) begin
        e_err = 1'b1;
        idle  = 0;
        pkt.delete();
      end else begin
        idle++;
      end
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".rdy"},  32'(rdy),   32'(!reset));
    chk({t, ".vld"},  32'(pvld),  32'(e_vld));
    chk({t, ".cfg"},  32'(cfgp),  32'(e_cfg));
    chk({t, ".drp"},  32'(drpp),  32'(e_drp));
    chk({t, ".err"},  32'(errp),  32'(e_err));
    chk({t, ".addr"}, 32'(paddr), 32'(e_addr));
    chk({t, ".data"}, pdata,      e_data);
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    vin = v;
    din = d;
    @(posedge clk);
    cyc++;
    model_edge(v && !reset, d);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    vin   = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int ec;
    int t0;
    logic [31:0] r;
    reset = 1'b1;
    vin   = 1'b0;
    din   = 32'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic config write
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe21);
    step(1'b1, 32'h1234_5678);
    chk("cfgw.vld",  32'(pvld),  32'd1);
    chk("cfgw.addr", 32'(paddr), 32'h21);
    chk("cfgw.data", pdata,      32'h1234_5678);
    chk("cfgw.cfg",  32'(cfgp),  32'd1);
    step(1'b0, 32'd0);
    chk("cfgw.once", 32'(pvld),  32'd0);

    // Non-matching key is dropped
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'h0001_0021);
    step(1'b1, 32'h0000_cafe);
    chk("nokey.drp", 32'(drpp), 32'd1);
    chk("nokey.vld", 32'(pvld), 32'd0);
    chk("nokey.hold", pdata,    32'h1234_5678);

    // Config without payload, then a normal packet
    step(1'b1, 32'h0000_0000);
    step(1'b1, 32'hffff_fe05);
    chk("nopld.err", 32'(errp), 32'd1);
    chk("nopld.vld", 32'(pvld), 32'd0);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe07);
    step(1'b1, 32'haaaa_5555);
    chk("nopld.next", 32'(paddr), 32'h07);

    // Timeout in PLD, then a clean packet
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe10);
    ec = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'd0);
      if (errp) ec++;
    end
    chk("tout.once", ec, 1);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe33);
    step(1'b1, 32'hdead_beef);
    chk("tout.next", 32'(paddr), 32'h33);
    chk("tout.data", pdata, 32'hdead_beef);

    // Timeout in KEY
    step(1'b1, 32'h0000_0000);
    ec = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'd0);
      if (errp) ec++;
    end
    chk("toutk.once", ec, 1);

    // Transfer on the timeout cycle wins
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe44);
    repeat (TO) step(1'b0, 32'd0);
    step(1'b1, 32'h5a5a_0001);
    chk("tedge.vld",  32'(pvld),  32'd1);
    chk("tedge.addr", 32'(paddr), 32'h44);

    // Back-to-back packets
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe00);
    step(1'b1, 32'h0000_0011);
    t0 = cyc;
    chk("b2b.a0", 32'(paddr), 32'h00);
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe01);
    step(1'b1, 32'h0000_0022);
    chk("b2b.gap", cyc - t0, 3);
    chk("b2b.vld", 32'(pvld), 32'd1);
    chk("b2b.a1",  32'(paddr), 32'h01);
    chk("b2b.d1",  pdata, 32'h0000_0022);

    // Reset mid-packet: following word becomes a header (type 01 -> drop)
    step(1'b1, 32'h0000_0002);
    step(1'b1, 32'hffff_fe21);
    do_reset();
    step(1'b1, 32'h1234_5678);
    chk("rmid.vld", 32'(pvld), 32'd0);
    step(1'b1, 32'hffff_fe21);
    chk("rmid.drp", 32'(drpp), 32'd1);
    chk("rmid.novld", 32'(pvld), 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: r = $urandom & 32'h0000_00c2;
        1: r = KEYV | 32'($urandom_range(0, 255));
        2: r = $urandom;
        default: r = 32'h0000_0002;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 59) == 0) begin
        repeat ($urandom_range(14, 20)) step(1'b0, 32'd0);
      end else begin
        step($urandom_range(0, 3) != 0, r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
